seq_calc_core: RTL and testbench
================================

Name: seq_calc_core

Overview:
Clocked, parametrised successor to the board-level 4-bit signed calculator. It latches a signed A/B operand pair and a 3-bit op code on a start handshake. It computes add, subtract, absolute value or a multi-cycle shift-add multiply. It returns a registered result, a sticky-per-op overflow flag and a one-cycle done pulse. It sits between the switch/key input logic and the seven-segment display drivers.

Parameters:
WIDTH, 4, operand/result width in bits, two's complement; legal range 2..16.

Ports:
CLOCK_50  in   1      system clock, all state on rising edge
RESET_N   in   1      asynchronous active-low reset
START     in   1      request; accepted on a rising edge when READY=1
OP        in   3      OP[2]=swap (0: X=A,Y=B; 1: X=B,Y=A); OP[1:0]: 00 add, 01 sub X-Y, 10 abs X, 11 mul X*Y
A         in   WIDTH  signed operand A
B         in   WIDTH  signed operand B
READY     out  1      high when idle and able to accept START
RESULT    out  WIDTH  signed result of last completed op, held until next completion
OVF       out  1      overflow of last completed op, held with RESULT
DONE      out  1      one-cycle pulse, RESULT/OVF updated this cycle

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, RESULT=0, OVF=0, DONE=0, READY=1. An in-flight op is discarded and no DONE is produced.
- States:
  - IDLE: READY=1. On START, latch OP/A/B and go to EXEC (op 00/01/10) or MUL (op 11).
  - EXEC: one cycle; compute from the latched values, register RESULT/OVF, DONE=1, go to IDLE.
  - MUL: WIDTH iterations, then a final sign/overflow cycle, then IDLE with DONE=1.
- Latency, counted from the capture edge k:
  - add/sub/abs: RESULT, OVF and DONE valid after edge k+1.
  - mul: valid after edge k+WIDTH+1.
- READY is low in EXEC and MUL.
- START while READY=0 is ignored. It is not queued.
- A/B/OP changes after capture have no effect on the op in flight.
- DONE is high in the cycle the core returns to IDLE, and READY is also high that cycle. A START in the DONE cycle is accepted, giving back-to-back operation.
- Arithmetic and overflow rules:
  - add: RESULT = (X+Y) mod 2^WIDTH. OVF = X and Y share a sign and RESULT sign differs.
  - sub: RESULT = (X-Y) mod 2^WIDTH. OVF = X and Y differ in sign and RESULT sign differs from X.
  - abs: RESULT = |X|. When X is the most-negative value (-2^(WIDTH-1)), RESULT = X unchanged and OVF=1.
  - mul:
    - Datapath: unsigned shift-add on magnitudes (most-negative magnitude fits in WIDTH unsigned bits), with a 2*WIDTH-bit accumulator. Negate if the signs differ.
    - RESULT = low WIDTH bits of the signed product.
    - OVF=1 if the full signed product is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
    - Zero operands still take the full WIDTH iterations (fixed latency).
- DONE never asserts twice for one op. It never asserts without a preceding accepted START.

Decomposition:
- Package calc_pkg:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ABS=2'b10, OP_MUL=2'b11, and the swap bit index 2;
  - state enum {IDLE, EXEC, MUL}.
- One sub-module, calc_shift_mul: iterative unsigned WIDTH×WIDTH multiplier with a load/busy/done interface.
- The top handles sign conversion, overflow and the FSM.

Test Plan (WIDTH=4):
1. OP=000, A=4, B=3, START 1 cycle → after edge k+1: RESULT=0111, OVF=0, DONE high exactly one cycle, READY low only during EXEC.
2. OP=000, A=7, B=1 → RESULT=1000, OVF=1. OP=100, A=-8, B=-1 → RESULT=0111, OVF=1. OP=000, A=-8, B=-8 → RESULT=0000, OVF=1. OP=000, A=-7, B=-1 → RESULT=1000, OVF=0.
3. OP=001, A=5, B=2 → 0011, OVF=0. OP=101, A=5, B=2 → 1101 (-3), OVF=0. OP=001, A=-8, B=1 → 0111, OVF=1. OP=001, A=0, B=-8 → 1000, OVF=1.
4. OP=010, A=-5 → 0101, OVF=0. OP=010, A=-8 → 1000, OVF=1. OP=110, B=0 → 0000, OVF=0.
5. OP=011, A=-3, B=2 → DONE after edge k+5, RESULT=1010, OVF=0, READY low edges k+1..k+4. A START pulse with different operands at k+2 is ignored. Next: A=4, B=4 → 0000, OVF=1. Then A=-8, B=1 → 1000, OVF=0.
6. RESET_N low for 1 cycle at k+2 of a multiply → RESULT=0, OVF=0, READY=1, no DONE. A following OP=000, A=1, B=1 → RESULT=0010, DONE once. A back-to-back START in the DONE cycle is accepted.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op encodings and FSM state type for the sequential calculator
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // OP[SWAP_BIT]=1 exchanges the roles of A and B before the operation
  localparam int SWAP_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

endpackage

// File: rtl/calc_shift_mul.sv
// rtl/calc_shift_mul.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module calc_shift_mul #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  // Load clears the accumulator; every busy cycle adds the shifted multiplicand
  // when the current multiplier bit is set. Always runs exactly WIDTH steps so
  // latency does not depend on operand values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
        r_cnt    <= CW'(WIDTH);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/seq_calc_core.sv
// rtl/seq_calc_core.sv - sequential signed calculator: add, sub, abs and iterative multiply
module seq_calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVF,
  output logic             DONE
);

  localparam int MSB = WIDTH - 1;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_result;
  logic                 r_ovf;
  logic                 r_done;

  logic [WIDTH-1:0]     w_x;
  logic [WIDTH-1:0]     w_y;
  logic [WIDTH-1:0]     w_mag_x;
  logic [WIDTH-1:0]     w_mag_y;
  logic                 w_accept;
  logic                 w_finish;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_abs;
  logic [2*WIDTH-1:0]   w_prod_u;
  logic [2*WIDTH-1:0]   w_prod_s;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_ovf;
  logic                 w_mul_busy;
  logic                 w_mul_done;

  assign w_x      = OP[SWAP_BIT] ? B : A;
  assign w_y      = OP[SWAP_BIT] ? A : B;
  // Most-negative value maps to 2^(WIDTH-1), which still fits unsigned
  assign w_mag_x  = w_x[MSB] ? -w_x : w_x;
  assign w_mag_y  = w_y[MSB] ? -w_y : w_y;
  assign w_accept = START && READY;
  assign w_finish = (r_state == EXEC) || ((r_state == MUL) && w_mul_done);

  calc_shift_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk     (CLOCK_50),
    .i_rst_n   (RESET_N),
    .i_load    (w_accept && (OP[1:0] == OP_MUL)),
    .i_a       (w_mag_x),
    .i_b       (w_mag_y),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod_u)
  );

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake output
  always_comb begin
    w_next = r_state;
    READY  = 1'b0;
    case (r_state)
      IDLE: begin
        READY = !w_mul_busy;
        if (w_accept) begin
          w_next = (OP[1:0] == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: w_next = IDLE;
      MUL:  if (w_mul_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the swapped operands and op so later input changes cannot disturb the op
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_op <= OP_ADD;
      r_x  <= '0;
      r_y  <= '0;
    end else if (w_accept) begin
      r_op <= OP[1:0];
      r_x  <= w_x;
      r_y  <= w_y;
    end
  end

  assign w_sum    = r_x + r_y;
  assign w_diff   = r_x - r_y;
  assign w_abs    = r_x[MSB] ? -r_x : r_x;
  assign w_prod_s = (r_x[MSB] ^ r_y[MSB]) ? -w_prod_u : w_prod_u;

  // Result and overflow selection from the latched operands
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (r_x[MSB] == r_y[MSB]) && (w_sum[MSB] != r_x[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (r_x[MSB] != r_y[MSB]) && (w_diff[MSB] != r_x[MSB]);
      end
      OP_ABS: begin
        w_alu_res = w_abs;
        // Only the most-negative value stays negative after negation
        w_alu_ovf = r_x[MSB] && w_abs[MSB];
      end
      default: begin
        w_alu_res = w_prod_s[WIDTH-1:0];
        // In range only when the upper WIDTH+1 bits are a pure sign extension
        w_alu_ovf = !((&w_prod_s[2*WIDTH-1:MSB]) || !(|w_prod_s[2*WIDTH-1:MSB]));
      end
    endcase
  end

  // Register the result and pulse DONE on the cycle the core returns to IDLE
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= w_alu_res;
        r_ovf    <= w_alu_ovf;
      end
    end
  end

  assign RESULT = r_result;
  assign OVF    = r_ovf;
  assign DONE   = r_done;

endmodule

// File: tb/tb_seq_calc_core.sv
// tb/tb_seq_calc_core.sv - scoreboard bench for seq_calc_core at WIDTH=4
module tb_seq_calc_core;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic [W-1:0] result;
  logic         ovf;
  logic         done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  seq_calc_core #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .START    (start),
    .OP       (op),
    .A        (a),
    .B        (b),
    .READY    (ready),
    .RESULT   (result),
    .OVF      (ovf),
    .DONE     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("ready_in_done", 32'(ready), 32'd1);
      end
    end
  end

  // Wait for READY, present one op, record capture edge k, push expectation
  task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] res, input logic eo, input bit push, output int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    op    = o;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    if (push) begin
      exp_t e;
      e.res = res;
      e.ovf = eo;
      e.due = k + ((o[1:0] == 2'b11) ? (W + 1) : 1);
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("ready_low_after_capture", 32'(ready), 32'd0);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0 && ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int k2;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;

    // Add basics and overflow corners
    issue(3'b000, 4'd4,     4'd3,     4'b0111, 1'b0, 1'b1, k);
    wait_idle();
    issue(3'b000, 4'd7,     4'd1,     4'b1000, 1'b1, 1'b1, k);
    issue(3'b100, 4'b1000,  4'b1111,  4'b0111, 1'b1, 1'b1, k);
    issue(3'b000, 4'b1000,  4'b1000,  4'b0000, 1'b1, 1'b1, k);
    issue(3'b000, 4'b1001,  4'b1111,  4'b1000, 1'b0, 1'b1, k);
    wait_idle();

    // Subtract, including swapped operands
    issue(3'b001, 4'd5,     4'd2,     4'b0011, 1'b0, 1'b1, k);
    issue(3'b101, 4'd5,     4'd2,     4'b1101, 1'b0, 1'b1, k);
    issue(3'b001, 4'b1000,  4'd1,     4'b0111, 1'b1, 1'b1, k);
    issue(3'b001, 4'd0,     4'b1000,  4'b1000, 1'b1, 1'b1, k);
    wait_idle();

    // Absolute value
    issue(3'b010, 4'b1011,  4'd0,     4'b0101, 1'b0, 1'b1, k);
    issue(3'b010, 4'b1000,  4'd0,     4'b1000, 1'b1, 1'b1, k);
    issue(3'b110, 4'b1000,  4'd0,     4'b0000, 1'b0, 1'b1, k);
    wait_idle();

    // Multiply: -3*2 with an ignored START while busy
    issue(3'b011, 4'b1101,  4'd2,     4'b1010, 1'b0, 1'b1, k);
    @(negedge clk);
    check("mul_ready_k1", 32'(ready), 32'd0);
    start = 1'b1;
    op    = 3'b000;
    a     = 4'd7;
    b     = 4'd7;
    @(negedge clk);
    check("mul_ready_k2", 32'(ready), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("mul_ready_k3", 32'(ready), 32'd0);
    @(negedge clk);
    check("mul_ready_k4", 32'(ready), 32'd0);
    @(negedge clk);
    check("mul_ready_k5", 32'(ready), 32'd1);
    wait_idle();
    issue(3'b011, 4'd4,     4'd4,     4'b0000, 1'b1, 1'b1, k);
    wait_idle();
    issue(3'b011, 4'b1000,  4'd1,     4'b1000, 1'b0, 1'b1, k);
    wait_idle();

    // Reset in the middle of a multiply discards it
    issue(3'b011, 4'd3,     4'd3,     4'b0000, 1'b0, 1'b0, k);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_ready", 32'(ready), 32'd1);
    check("postrst_result", 32'(result), 32'd0);

    // Back-to-back: second START lands in the DONE cycle of the first
    issue(3'b000, 4'd1,     4'd1,     4'b0010, 1'b0, 1'b1, k);
    issue(3'b000, 4'd2,     4'd3,     4'b0101, 1'b0, 1'b1, k2);
    check("b2b_capture_edge", 32'(k2), 32'(k + 2));
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
